// File: rtl/syst_pkg.sv
// Shared constants and state encoding for the systolic-array job controller.
package syst_pkg;
  localparam int unsigned WORD  = 32;
  localparam int unsigned LANE  = 8;
  localparam int unsigned LANES = WORD / LANE;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/syst_ctrl_fifo.sv
// First-word-fall-through FIFO holding array results until the consumer takes them.
module syst_ctrl_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/syst_ctrl.sv
// Job controller: credit-gated issue of input vectors to the array and
// buffering of its results for the output stream.
module syst_ctrl #(
  parameter int unsigned WORD      = syst_pkg::WORD,
  parameter int unsigned LEN_W     = syst_pkg::LEN_W,
  parameter int unsigned OUT_DEPTH = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [WORD-1:0]  in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WORD-1:0]  arr_data_o,
  output logic             arr_valid_o,
  input  logic [WORD-1:0]  arr_data_i,
  input  logic             arr_valid_i,
  output logic [WORD-1:0]  out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  import syst_pkg::*;

  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(OUT_DEPTH);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_t           state;
  logic [LEN_W-1:0] len_q, issued, received;
  logic [CW-1:0]    credits;
  logic [TW-1:0]    tmo_cnt;
  logic             fire, pop, capture, stray, flush;
  logic             fifo_full, fifo_empty;
  logic [WORD-1:0]  fifo_head;

  assign in_ready_o  = (state == RUN) && (credits != '0) && (issued < len_q);
  assign fire        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  // Results are only stored while a job can still expect them; anything else is an error.
  assign capture     = arr_valid_i && (state == RUN || state == DRAIN) && (received < len_q)
                       && !(fifo_full && !pop);
  assign stray       = arr_valid_i && !capture;
  assign flush       = (state == DRAIN) && !(received == len_q && fifo_empty)
                       && !arr_valid_i && (tmo_cnt == TMO_LAST);
  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_empty ? '0 : fifo_head;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);

  syst_ctrl_fifo #(
    .WIDTH (WORD),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (capture),
    .pop   (pop),
    .flush (flush),
    .din   (arr_data_i),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      len_q       <= '0;
      issued      <= '0;
      received    <= '0;
      tmo_cnt     <= '0;
      credits     <= CREDIT_MAX;
      err_o       <= 1'b0;
      arr_valid_o <= 1'b0;
      arr_data_o  <= '0;
    end else begin
      arr_valid_o <= fire;
      if (fire) arr_data_o <= in_data_i;

      if (flush)
        credits <= CREDIT_MAX;
      else if (fire && !pop)
        credits <= credits - CW'(1);
      else if (pop && !fire && credits != CREDIT_MAX)
        credits <= credits + CW'(1);

      if (capture) received <= received + LEN_W'(1);
      if (stray)   err_o    <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start_i) begin
            len_q    <= len_i;
            issued   <= '0;
            received <= '0;
            tmo_cnt  <= '0;
            err_o    <= stray;
            state    <= (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fire) begin
            issued <= issued + LEN_W'(1);
            if (issued == len_q - LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (received == len_q && fifo_empty) begin
            state <= DONE;
          end else if (arr_valid_i) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            err_o <= 1'b1;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_syst_ctrl.sv
// Scoreboard bench for syst_ctrl with a 10-cycle delay-line model of the array.
module tb_syst_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] len_i;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] arr_data_o;
  logic        arr_valid_o;
  logic [31:0] arr_data_i;
  logic        arr_valid_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        busy_o, done_o, err_o;

  syst_ctrl #(
    .WORD      (32),
    .LEN_W     (16),
    .OUT_DEPTH (16),
    .TIMEOUT   (1024)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .arr_data_o  (arr_data_o),
    .arr_valid_o (arr_valid_o),
    .arr_data_i  (arr_data_i),
    .arr_valid_i (arr_valid_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Array stub: fixed latency, optionally swallows one chosen result.
  logic [31:0] dl_data [10];
  logic [9:0]  dl_valid;
  int          stub_cnt;
  logic        drop_en = 1'b0;
  int          drop_at = 0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dl_valid <= '0;
      stub_cnt <= 0;
    end else begin
      dl_valid <= {dl_valid[8:0], arr_valid_o && !(drop_en && stub_cnt == drop_at)};
      dl_data[0] <= arr_data_o;
      for (int i = 1; i < 10; i++) dl_data[i] <= dl_data[i-1];
      if (arr_valid_o) stub_cnt <= stub_cnt + 1;
    end
  end
  assign arr_valid_i = dl_valid[9];
  assign arr_data_i  = dl_data[9];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] vec[$];
  int fire_cnt = 0, pop_cnt = 0, done_cnt = 0, arrv_cnt = 0, arro_cnt = 0;
  int last_pop_cyc = 0, last_arrv_cyc = 0;

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (in_valid_i && in_ready_o) begin
          exp_q.push_back(in_data_i);
          fire_cnt++;
        end
        if (out_valid_o && out_ready_i) begin
          check("out_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("out_data", out_data_o, exp_q.pop_front());
          pop_cnt++;
          last_pop_cyc = cyc;
        end
        if (done_o) done_cnt++;
        if (arr_valid_i) begin
          arrv_cnt++;
          last_arrv_cyc = cyc;
        end
        if (arr_valid_o) arro_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input logic [15:0] len);
    start_i = 1'b1;
    len_i   = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic feed(input string tag, input int n, input int budget);
    int idx = 0;
    int k = 0;
    in_valid_i = 1'b1;
    in_data_i  = vec[0];
    while (idx < n && k < budget) begin
      @(negedge clk_i);
      if (in_ready_o) idx++;
      tick();
      k++;
      if (idx < n) in_data_i = vec[idx];
    end
    in_valid_i = 1'b0;
    check(tag, idx, n);
  endtask

  task automatic wait_done(input string tag, input int budget, output int at);
    int k = 0;
    at = -1;
    while (k < budget) begin
      @(negedge clk_i);
      if (done_o) begin
        at = cyc;
        break;
      end
      k++;
    end
    check(tag, at >= 0, 1);
  endtask

  task automatic fill_vec(input int n);
    vec.delete();
    for (int i = 0; i < n; i++) vec.push_back($urandom);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin : stimulus
    int at, pops0, done0, fires0, arro0, arrv0, seen;
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs", {in_ready_o, arr_valid_o, arr_data_o, out_valid_o, out_data_o, busy_o, done_o, err_o}, '0);
    rst_i = 1'b0;
    tick();

    // 1: short job at full output rate
    out_ready_i = 1'b1;
    vec = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    pops0 = pop_cnt; done0 = done_cnt; arro0 = arro_cnt;
    start_job(16'd4);
    check("t1_busy_after_start", busy_o, 1'b1);
    feed("t1_feed", 4, 50);
    wait_done("t1_done_seen", 200, at);
    check("t1_busy_at_done", busy_o, 1'b1);
    check("t1_done_after_last_pop", at > last_pop_cyc, 1);
    check("t1_pops", pop_cnt - pops0, 4);
    check("t1_arr_issues", arro_cnt - arro0, 4);
    check("t1_err", err_o, 1'b0);
    tick();
    check("t1_busy_cleared", busy_o, 1'b0);
    check("t1_done_once", done_cnt - done0, 1);

    // 2: stalled output limits issue to the FIFO depth
    out_ready_i = 1'b0;
    fill_vec(40);
    pops0 = pop_cnt; fires0 = fire_cnt;
    start_job(16'd40);
    fork
      feed("t2_feed", 40, 2000);
      begin
        repeat (60) @(negedge clk_i);
        check("t2_fires_stalled", fire_cnt - fires0, 16);
        check("t2_ready_low", in_ready_o, 1'b0);
        check("t2_out_valid", out_valid_o, 1'b1);
        tick();
        out_ready_i = 1'b1;
      end
    join
    wait_done("t2_done_seen", 500, at);
    check("t2_pops", pop_cnt - pops0, 40);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_err", err_o, 1'b0);
    tick();

    // 3: zero-length job
    done0 = done_cnt; arro0 = arro_cnt;
    start_job(16'd0);
    check("t3_busy", busy_o, 1'b1);
    check("t3_done", done_o, 1'b1);
    check("t3_in_ready", in_ready_o, 1'b0);
    tick();
    check("t3_busy_cleared", {busy_o, done_o}, 2'b00);
    repeat (5) tick();
    check("t3_no_issue", arro_cnt - arro0, 0);
    check("t3_done_once", done_cnt - done0, 1);

    // 4: start re-pulsed mid-job is ignored
    fill_vec(5);
    pops0 = pop_cnt; done0 = done_cnt;
    start_job(16'd5);
    fork
      feed("t4_feed", 5, 100);
      begin
        repeat (2) tick();
        start_i = 1'b1;
        len_i   = 16'd7;
        tick();
        start_i = 1'b0;
      end
    join
    wait_done("t4_done_seen", 200, at);
    repeat (30) tick();
    check("t4_pops", pop_cnt - pops0, 5);
    check("t4_done_once", done_cnt - done0, 1);
    check("t4_idle", busy_o, 1'b0);

    // 5: lost result triggers timeout, flush and error
    out_ready_i = 1'b0;
    fill_vec(3);
    arrv0 = arrv_cnt;
    drop_en = 1'b1;
    drop_at = stub_cnt + 2;
    start_job(16'd3);
    feed("t5_feed", 3, 50);
    wait_done("t5_done_seen", 1500, at);
    check("t5_timeout_cycles", at - last_arrv_cyc, 1025);
    check("t5_err", err_o, 1'b1);
    check("t5_flushed", out_valid_o, 1'b0);
    check("t5_results_seen", arrv_cnt - arrv0, 2);
    check("t5_pending", exp_q.size(), 3);
    exp_q.delete();
    drop_en = 1'b0;
    tick();
    out_ready_i = 1'b1;
    fill_vec(1);
    pops0 = pop_cnt;
    start_job(16'd1);
    check("t5_err_cleared", err_o, 1'b0);
    feed("t5b_feed", 1, 50);
    wait_done("t5b_done_seen", 200, at);
    check("t5b_pops", pop_cnt - pops0, 1);
    tick();

    // 6: reset in the middle of a job, then a fresh job
    out_ready_i = 1'b0;
    fill_vec(8);
    done0 = done_cnt;
    start_job(16'd8);
    feed("t6_feed", 8, 50);
    seen = 0;
    for (int k = 0; k < 100 && seen < 3; k++) begin
      @(negedge clk_i);
      if (arr_valid_i) seen++;
    end
    check("t6_results_reached", seen, 3);
    @(posedge clk_i);
    #1;
    check("t6_fifo_loaded", out_valid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("t6_reset_outputs", {in_ready_o, arr_valid_o, arr_data_o, out_valid_o, out_data_o, busy_o, done_o, err_o}, '0);
    repeat (2) @(posedge clk_i);
    #1;
    exp_q.delete();
    rst_i = 1'b0;
    check("t6_no_done", done_cnt - done0, 0);
    tick();
    out_ready_i = 1'b1;
    fill_vec(2);
    pops0 = pop_cnt;
    start_job(16'd2);
    feed("t6b_feed", 2, 50);
    wait_done("t6b_done_seen", 200, at);
    check("t6b_pops", pop_cnt - pops0, 2);
    check("t6b_err", err_o, 1'b0);
    check("t6b_done_once", done_cnt - done0, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
